spdif_encoder: RTL and testbench

- S/PDIF (IEC 60958) transmitter: accepts one 28-bit subframe payload (time slots 4..31) plus a preamble code per handshake.
- Serialises the subframe as biphase-mark code (BMC) on a single line, with an 8-UI preamble.
- Mirror of the receive path (edge detector + decoder); uses the same 28-bit package layout and 3-bit preamble encoding, so a loopback bench can compare TX input against RX output directly.

---
 rtl/spdif_encoder.sv | 73 +++++++
 tb/tb_spdif_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_encoder.sv
// spdif_encoder: IEC 60958 subframe serialiser producing a biphase-mark line with 8-UI preambles
module spdif_encoder #(
  parameter int DIV = 4,
  parameter bit PARITY_GEN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [27:0] package_i,
  input  logic [2:0]  preamble_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        spdif_o,
  output logic        busy_o,
  output logic        underrun_o
);
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
  localparam logic [7:0] last_cnt = 8'(DIV - 1);
  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  ui;
  logic [5:0]  nu;
  logic [27:0] sr;
  logic [7:0]  pat;
  logic [7:0]  pre_lv;
  logic        wrap;
  logic        xfer;
  assign wrap    = cnt == last_cnt;
  assign ready_o = state == IDLE || (ui == 6'd63 && wrap);
  assign xfer    = valid_i && ready_o;
  assign nu      = ui + 6'd1;
  assign pre_lv  = (preamble_i[0] ? 8'hE8 : preamble_i[1] ? 8'hE2 : 8'hE4) ^ {8{spdif_o}};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      ui         <= 6'd0;
      sr         <= 28'd0;
      pat        <= 8'd0;
      spdif_o    <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else if (xfer) begin
      state      <= PRE;
      cnt        <= 8'd0;
      ui         <= 6'd0;
      sr         <= {PARITY_GEN ? ^package_i[26:0] : package_i[27], package_i[26:0]};
      pat        <= {pre_lv[6:0], 1'b0};
      spdif_o    <= pre_lv[7];
      busy_o     <= 1'b1;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (state != IDLE) begin
        cnt <= wrap ? 8'd0 : cnt + 8'd1;
        if (wrap) begin
          ui <= nu;
          if (ui == 6'd63) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            underrun_o <= 1'b1;
          end else if (nu < 6'd8) begin
            spdif_o <= pat[7];
            pat     <= {pat[6:0], 1'b0};
          end else begin
            state   <= DATA;
            spdif_o <= nu[0] ? spdif_o ^ sr[0] : ~spdif_o;
            if (nu[0]) sr <= sr >> 1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spdif_encoder.sv
// tb_spdif_encoder: self-checking bench for spdif_encoder against a per-cycle line model
module tb_spdif_encoder;
  logic        clk;
  logic        rst   [2];
  logic        valid [2];
  logic        ready [2];
  logic        spdif [2];
  logic        busy  [2];
  logic        urun  [2];
  logic [2:0]  pre   [2];
  logic [27:0] pkg   [2];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          go = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  spdif_encoder #(.DIV(2), .PARITY_GEN(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .package_i(pkg[0]), .preamble_i(pre[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .spdif_o(spdif[0]), .busy_o(busy[0]), .underrun_o(urun[0])
  );
  spdif_encoder #(.DIV(1), .PARITY_GEN(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .package_i(pkg[1]), .preamble_i(pre[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .spdif_o(spdif[1]), .busy_o(busy[1]), .underrun_o(urun[1])
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got timeout expected event at cycle %0d", nm, cyc);
  endtask
  function automatic int dv(input int d);
    return d == 0 ? 2 : 1;
  endfunction
  function automatic logic [63:0] ui_stream(input logic [2:0] pr, input logic [27:0] pk, input logic l, input bit pg);
    logic [7:0]  p;
    logic [63:0] s;
    logic [27:0] b;
    logic        lv, u0, u1;
    p = pr[0] ? 8'b11101000 : pr[1] ? 8'b11100010 : 8'b11100100;
    p = p ^ {8{l}};
    b = pk;
    if (pg) b[27] = ^pk[26:0];
    s = {p, 56'd0};
    lv = p[0];
    for (int j = 0; j < 28; j++) begin
      u0 = ~lv;
      u1 = b[j] ? ~u0 : u0;
      s[55-2*j] = u0;
      s[54-2*j] = u1;
      lv = u1;
    end
    return s;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : m
    localparam int D = g == 0 ? 2 : 1;
    localparam bit P = g == 0;
    logic        q[$];
    logic        line = 1'b0;
    logic        bsy = 1'b0;
    logic        ur, xf;
    logic [63:0] s;
    always @(posedge clk) begin
      xf = valid[g] && ready[g] && !rst[g];
      ur = 1'b0;
      if (rst[g]) begin
        q.delete();
        line = 1'b0;
        bsy = 1'b0;
      end else begin
        if (xf) begin
          s = ui_stream(pre[g], pkg[g], line, P);
          q.delete();
          for (int k = 0; k < 64; k++)
            for (int r = 0; r < D; r++) q.push_back(s[63-k]);
          bsy = 1'b1;
        end
        if (q.size() > 0) line = q.pop_front();
        else if (bsy) begin
          bsy = 1'b0;
          ur = 1'b1;
        end
      end
      #1;
      if (go) begin
        chk($sformatf("line%0d", g), 64'(spdif[g]), 64'(line));
        chk($sformatf("busy%0d", g), 64'(busy[g]), 64'(bsy));
        chk($sformatf("ready%0d", g), 64'(ready[g]), 64'(q.size() == 0));
        chk($sformatf("underrun%0d", g), 64'(urun[g]), 64'(ur));
      end
    end
  end
  task automatic start(input int d, input logic [2:0] pr, input logic [27:0] pk);
    int n;
    @(negedge clk);
    pre[d] = pr;
    pkg[d] = pk;
    valid[d] = 1'b1;
    n = 0;
    while (!ready[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready[d]) timeout("ready_wait");
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
  endtask
  task automatic send_capture(input int d, input logic [2:0] pr, input logic [27:0] pk, output logic [63:0] s);
    start(d, pr, pk);
    s[63] = spdif[d];
    for (int k = 1; k < 64; k++) begin
      repeat (dv(d)) @(posedge clk);
      #1;
      s[63-k] = spdif[d];
    end
  endtask
  task automatic wait_idle(input int d, output int pulses);
    int idle;
    pulses = 0;
    idle = 0;
    for (int n = 0; n < 400 && idle < 4; n++) begin
      @(negedge clk);
      if (urun[d]) pulses++;
      idle = busy[d] ? 0 : idle + 1;
    end
    if (idle < 4) timeout("idle_wait");
  endtask
  typedef struct {
    int          d;
    logic [2:0]  pr;
    logic [27:0] pk;
    logic [63:0] exp;
  } vec_t;
  vec_t        tbl[7];
  logic [2:0]  seq[4];
  logic [63:0] s;
  logic [2:0]  pr;
  logic [27:0] pk;
  int          pulses, tprev, n;
  initial begin
    tbl[0] = '{0, 3'b001, 28'h0000000, 64'hE8CC_CCCC_CCCC_CCCC};
    tbl[1] = '{0, 3'b010, 28'h0000001, 64'hE2B3_3333_3333_3332};
    tbl[2] = '{0, 3'b100, 28'h0000000, 64'hE4CC_CCCC_CCCC_CCCC};
    tbl[3] = '{1, 3'b001, 28'h0000001, 64'hE8B3_3333_3333_3333};
    tbl[4] = '{1, 3'b100, 28'h0000000, 64'h1B33_3333_3333_3333};
    tbl[5] = '{1, 3'b010, 28'h0000000, 64'h1D33_3333_3333_3333};
    tbl[6] = '{1, 3'b000, 28'h0000000, 64'h1B33_3333_3333_3333};
    seq = '{3'b001, 3'b100, 3'b010, 3'b100};
    rst = '{1'b1, 1'b1};
    valid = '{1'b1, 1'b1};
    pre = '{3'b001, 3'b001};
    pkg = '{28'd0, 28'd0};
    @(posedge clk);
    #2 go = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_spdif", 64'(spdif[0]), 64'd0);
    chk("rst_ready", 64'(ready[0]), 64'd1);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    rst = '{1'b0, 1'b0};
    @(posedge clk);
    #1;
    chk("release_xfer0", 64'(busy[0]), 64'd1);
    chk("release_xfer1", 64'(busy[1]), 64'd1);
    @(negedge clk);
    valid = '{1'b0, 1'b0};
    wait_idle(0, pulses);
    wait_idle(1, pulses);
    foreach (tbl[i]) begin
      send_capture(tbl[i].d, tbl[i].pr, tbl[i].pk, s);
      chk($sformatf("tbl_stream%0d", i), s, tbl[i].exp);
      wait_idle(tbl[i].d, pulses);
      chk($sformatf("tbl_underrun%0d", i), 64'(pulses), 64'd1);
    end
    @(negedge clk);
    valid[0] = 1'b1;
    tprev = 0;
    foreach (seq[i]) begin
      pre[0] = seq[i];
      pkg[0] = 28'($urandom);
      n = 0;
      while (!ready[0] && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!ready[0]) timeout("b2b_ready");
      if (i > 0) chk("b2b_spacing", 64'(cyc - tprev), 64'd128);
      tprev = cyc;
      @(negedge clk);
      chk("b2b_ready_low", 64'(ready[0]), 64'd0);
    end
    valid[0] = 1'b0;
    wait_idle(0, pulses);
    chk("b2b_underrun", 64'(pulses), 64'd1);
    start(0, 3'b001, 28'($urandom));
    repeat (60) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_spdif", 64'(spdif[0]), 64'd0);
    chk("mrst_busy", 64'(busy[0]), 64'd0);
    chk("mrst_ready", 64'(ready[0]), 64'd1);
    @(negedge clk);
    rst[0] = 1'b0;
    pr = 3'b010;
    pk = 28'($urandom);
    send_capture(0, pr, pk, s);
    chk("mrst_stream", s, ui_stream(pr, pk, 1'b0, 1'b1));
    wait_idle(0, pulses);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 2) == 0) wait_idle(d, pulses);
        start(d, 3'($urandom), 28'($urandom));
      end
      wait_idle(d, pulses);
      chk("rand_underrun", 64'(pulses), 64'd1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
